mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer.sv | 115 +++++++++++
 tb/tb_mul_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - 16x16 unsigned shift-add multiplier, one CLA add per step.
// Optional MUL_SEQUENCER_ZERO_SKIP_EN: zero operand goes straight to DONE with product 0.
module mul_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] ra,
  input  logic [15:0] rb,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, next_state;
  logic [15:0] mcand;
  logic [31:0] p;
  logic [31:0] p_next;
  logic [3:0]  cnt;
  logic [15:0] sum;
  logic        cout;
  logic        skip;

  logic [15:0] g, pr;
  logic [3:0]  grp_g, grp_p, grp_cin;
  logic        carry;

`ifdef MUL_SEQUENCER_ZERO_SKIP_EN
  assign skip = (ra == 16'h0) || (rb == 16'h0);
`else
  assign skip = 1'b0;
`endif

  // Carry-lookahead over 4-bit groups: group generate/propagate feed the group carries
  always_comb begin
    g       = p[31:16] & mcand;
    pr      = p[31:16] ^ mcand;
    grp_g   = '0;
    grp_p   = '0;
    grp_cin = '0;
    sum     = '0;
    for (int j = 0; j < 4; j++) begin
      grp_g[j] = g[4*j+3]
               | (pr[4*j+3] & g[4*j+2])
               | (pr[4*j+3] & pr[4*j+2] & g[4*j+1])
               | (pr[4*j+3] & pr[4*j+2] & pr[4*j+1] & g[4*j]);
      grp_p[j] = &pr[4*j +: 4];
    end
    carry = 1'b0;
    for (int j = 0; j < 4; j++) begin
      grp_cin[j] = carry;
      carry      = grp_g[j] | (grp_p[j] & carry);
    end
    cout = carry;
    for (int j = 0; j < 4; j++) begin
      carry = grp_cin[j];
      for (int k = 0; k < 4; k++) begin
        sum[4*j+k] = pr[4*j+k] ^ carry;
        carry      = g[4*j+k] | (pr[4*j+k] & carry);
      end
    end
  end

  always_comb begin
    p_next = p[0] ? {cout, sum, p[15:1]} : {1'b0, p[31:1]};
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = skip ? DONE : RUN;
      RUN:     if (cnt == 4'd15) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      p       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= ra;
            cnt   <= '0;
            if (skip) begin
              p       <= '0;
              product <= '0;
            end else begin
              p <= {16'h0, rb};
            end
          end
        end
        RUN: begin
          p   <= p_next;
          cnt <= cnt + 4'd1;
          // Final step: publish the result as we enter DONE
          if (cnt == 4'd15) product <= p_next;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - randomized self-checking bench for mul_sequencer.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ra = '0;
  logic [15:0] rb = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int total = 0;
  int bad = 0;

  mul_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ra(ra), .rb(rb),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_latency(input logic [15:0] a, input logic [15:0] b);
`ifdef MUL_SEQUENCER_ZERO_SKIP_EN
    if (a == 16'h0 || b == 16'h0) return 1;
`endif
    return 17;
  endfunction

  // One operation: start pulse, operands scrambled after acceptance,
  // optional ignored start injected at cycle poke, then latency/busy/product checks.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int poke);
    int n;
    int busy_cnt;
    logic [31:0] exp_p;
    exp_p = 32'(a) * 32'(b);
    @(negedge clk);
    start = 1'b1; ra = a; rb = b;
    @(negedge clk);
    start = 1'b0; ra = 16'($urandom); rb = 16'($urandom);
    n = 1; busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
      start = (n == poke);
      if (n == poke) begin ra = 16'd2; rb = 16'd2; end
    end
    start = 1'b0;
    check("latency", 32'(n), 32'(exp_latency(a, b)));
    check("product", product, exp_p);
    check("busy_run", 32'(busy_cnt), 32'(n - 1));
    check("busy_done", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("done_pulse", {31'h0, done}, 32'h0);
    check("idle_busy", {31'h0, busy}, 32'h0);
    check("product_hold", product, exp_p);
  endtask

  initial begin
    int seen;
    int first_t, last_t, gap_ok;
    logic [15:0] a, b;

    #12;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_product", product, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'd3, 16'd5, 0);
    run_op(16'hFFFF, 16'hFFFF, 0);
    run_op(16'd7, 16'd9, 5);
    run_op(16'd2, 16'd2, 0);
    run_op(16'd0, 16'h1234, 0);
    run_op(16'h8000, 16'h0001, 0);

    // Reset mid-run aborts with no done and clears product at once
    @(negedge clk);
    start = 1'b1; ra = 16'd123; rb = 16'd45;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_product", product, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'h0);
    run_op(16'd10, 16'd10, 0);

    // Random operands, occasionally zero
    for (int i = 0; i < 10; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      run_op(a, b, $urandom_range(2, 12));
    end

    // start held 40 cycles: back-to-back operations 18 cycles apart
    @(negedge clk);
    start = 1'b1; ra = 16'd2; rb = 16'd3;
    seen = 0; first_t = -1; last_t = -1; gap_ok = 1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 40) start = 1'b0;
      if (done) begin
        check("b2b_product", product, 32'h6);
        if (last_t >= 0 && (k - last_t) != 18) gap_ok = 0;
        if (first_t < 0) first_t = k;
        last_t = k;
        seen++;
      end
    end
    check("b2b_count", 32'(seen), (exp_latency(16'd2, 16'd3) == 17) ? 32'd3 : 32'd20);
    check("b2b_first", 32'(first_t), 32'(exp_latency(16'd2, 16'd3)));
    check("b2b_spacing", 32'(gap_ok), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
